// File: rtl/comparator_nbit_serial.sv
// Bit-serial N-bit magnitude comparator: operands are latched on start, then compared
// MSB first, one bit per clock, stopping at the first differing bit.
module comparator_nbit_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             a_maior_que_b,
  output logic             a_menor_que_b,
  output logic             a_igual_b
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] MSB_IDX = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPARE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sm_q, sm_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;
  logic             eq_q, eq_d;
  logic             bit_a_s;
  logic             bit_b_s;
  logic             at_msb_s;

  assign bit_a_s  = a_q[idx_q];
  assign bit_b_s  = b_q[idx_q];
  assign at_msb_s = (idx_q == MSB_IDX);

  // Next-state, operand latch and result update logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sm_d    = sm_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sm_d    = signed_mode;
          idx_d   = MSB_IDX;
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          eq_d    = 1'b0;
          state_d = S_COMPARE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_COMPARE: begin
        if (bit_a_s != bit_b_s) begin
          state_d = S_DONE;
          // In signed mode a set MSB marks a negative operand, so the sense flips
          if (sm_q && at_msb_s) begin
            gt_d = ~bit_a_s;
            lt_d = bit_a_s;
          end else begin
            gt_d = bit_a_s;
            lt_d = ~bit_a_s;
          end
        end else if (idx_q == {IW{1'b0}}) begin
          eq_d    = 1'b1;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q - {{(IW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= {IW{1'b0}};
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      sm_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sm_q    <= sm_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
    end
  end

  assign busy          = (state_q == S_COMPARE);
  assign done          = (state_q == S_DONE);
  assign a_maior_que_b = gt_q;
  assign a_menor_que_b = lt_q;
  assign a_igual_b     = eq_q;

endmodule

// File: tb/tb_comparator_nbit_serial.sv
// Directed and random self-checking bench for comparator_nbit_serial at WIDTH=8.
module tb_comparator_nbit_serial;

  logic       clk;
  logic       rst;
  logic       start;
  logic       sm;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic       gt;
  logic       lt;
  logic       eq;

  int checks   = 0;
  int failures = 0;

  comparator_nbit_serial #(.WIDTH(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .signed_mode   (sm),
    .a             (a),
    .b             (b),
    .busy          (busy),
    .done          (done),
    .a_maior_que_b (gt),
    .a_menor_que_b (lt),
    .a_igual_b     (eq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] ref_res(input logic [7:0] av, input logic [7:0] bv, input logic smv);
    logic less;
    if (av == bv) return 3'b001;
    less = smv ? ($signed(av) < $signed(bv)) : (av < bv);
    return less ? 3'b010 : 3'b100;
  endfunction

  function automatic int ref_n(input logic [7:0] av, input logic [7:0] bv);
    logic [7:0] x;
    x = av ^ bv;
    for (int i = 7; i >= 0; i--) begin
      if (x[i]) return 8 - i;
    end
    return 8;
  endfunction

  // One full operation: accept, count busy cycles, check done/results and the hold cycle.
  task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic smv, input logic [2:0] exp_res, input int exp_n,
                        input bit disturb);
    int n;
    a = av; b = bv; sm = smv; start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      if (n == 0) chk({tag, "_cleared"}, {gt, lt, eq}, 3'b000);
      chk({tag, "_done_while_busy"}, done, 1'b0);
      if (disturb && n == 1) begin
        a = ~av; b = ~bv; sm = ~smv; start = 1'b1;
      end
      if (disturb && n == 2) start = 1'b0;
      n++;
      step();
    end
    chk({tag, "_busy_cycles"}, n, exp_n);
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_result"}, {gt, lt, eq}, exp_res);
    step();
    chk({tag, "_done_pulse_end"}, {done, busy}, 2'b00);
    chk({tag, "_result_held"}, {gt, lt, eq}, exp_res);
  endtask

  initial begin
    logic [7:0] ca, cb, na, nb;
    logic       csm, nsm;
    int         n;
    bit         saw_done;

    rst = 1'b1; start = 1'b1; sm = 1'b1; a = 8'h00; b = 8'h00;
    for (int i = 0; i < 2; i++) begin
      a = 8'($urandom); b = 8'($urandom); sm = 1'($urandom);
      step();
    end
    chk("reset_outputs", {busy, done, gt, lt, eq}, 5'b00000);
    rst = 1'b0; start = 1'b0;
    step();
    chk("reset_idle", {busy, done, gt, lt, eq}, 5'b00000);

    run_op("msb", 8'hA5, 8'h5A, 1'b0, 3'b100, 1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      a = 8'($urandom); b = 8'($urandom); sm = 1'($urandom);
      step();
    end
    chk("msb_hold_long", {busy, done, gt, lt, eq}, 5'b00100);

    run_op("lsb_diff", 8'h3C, 8'h3D, 1'b0, 3'b010, 8, 1'b0);
    run_op("equal",    8'h77, 8'h77, 1'b0, 3'b001, 8, 1'b0);
    run_op("s_80_01",  8'h80, 8'h01, 1'b1, 3'b010, 1, 1'b0);
    run_op("u_80_01",  8'h80, 8'h01, 1'b0, 3'b100, 1, 1'b0);
    run_op("s_ff_fe",  8'hFF, 8'hFE, 1'b1, 3'b100, 8, 1'b0);
    run_op("ignore",   8'h01, 8'h02, 1'b0, 3'b010, 7, 1'b1);

    // Abort with reset in the 4th COMPARE cycle
    a = 8'h3C; b = 8'h3D; sm = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("abort_busy", busy, 1'b1);
      step();
    end
    chk("abort_busy4", busy, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_outputs", {busy, done, gt, lt, eq}, 5'b00000);
    saw_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done || busy) saw_done = 1'b1;
    end
    chk("abort_no_done", saw_done, 1'b0);

    // Back-to-back with start held high and a random reference-checked stream
    ca = 8'($urandom); cb = 8'($urandom); csm = 1'b0;
    a = ca; b = cb; sm = csm; start = 1'b1;
    step();
    for (int k = 0; k < 200; k++) begin
      na = 8'($urandom);
      nb = ($urandom_range(0, 7) == 0) ? na : 8'($urandom);
      nsm = ~csm;
      a = na; b = nb; sm = nsm;
      n = 0;
      while (busy && n < 20) begin
        n++;
        step();
      end
      chk("b2b_busy_cycles", n, ref_n(ca, cb));
      chk("b2b_done", done, 1'b1);
      chk("b2b_result", {gt, lt, eq}, ref_res(ca, cb, csm));
      if (k == 199) start = 1'b0;
      step();
      if (k != 199) begin
        chk("b2b_no_gap", {busy, done, gt, lt, eq}, 5'b10000);
      end else begin
        chk("b2b_final_hold", {busy, done, gt, lt, eq}, {2'b00, ref_res(ca, cb, csm)});
      end
      ca = na; cb = nb; csm = nsm;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
